// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: round-robin over NUM_REQ writers into one registered write port.
// Latency: accept in cycle N -> regwrite/REG_address_wb/data_wb/grant_id valid in cycle N+1.
// Backpressure: stall freezes the output stage and rr_ptr and forces req_ready to zero.
// Optional build macro: REGWB_ZERO_FILTER_EN (accepted address-0 writes are consumed but not written).
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_REQ-1:0]                            req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]                     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]                     req_data,
    output logic [NUM_REQ-1:0]                            req_ready,
    input  logic                                          stall,
    output logic                                          regwrite,
    output logic [ADDR_W-1:0]                             REG_address_wb,
    output logic [DATA_W-1:0]                             data_wb,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ID_W:0] NUM_REQ_C = (ID_W+1)'(NUM_REQ);

    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   w_win;
    logic              w_found;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_accept;
    logic              w_load;
    logic [ID_W-1:0]   w_next_ptr;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [ID_W:0] v_idx;
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (v_idx >= NUM_REQ_C) begin
                v_idx = v_idx - NUM_REQ_C;
            end
            if (!w_found && req_valid[v_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = v_idx[ID_W-1:0];
            end
        end
    end

    // Select the winner's address/data and drive the one-hot ready (zero under stall or reset).
    always_comb begin
        w_addr    = '0;
        w_data    = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                w_addr       = req_addr[i*ADDR_W +: ADDR_W];
                w_data       = req_data[i*DATA_W +: DATA_W];
                req_ready[i] = w_found && !stall && reset;
            end
        end
    end

    assign w_accept   = w_found && !stall && reset;
    assign w_next_ptr = (w_win == ID_W'(NUM_REQ-1)) ? '0 : w_win + ID_W'(1);

`ifdef REGWB_ZERO_FILTER_EN
    // Address-0 writes are handshaken (requester moves on) but never reach the register file.
    assign w_load = w_accept && (w_addr != '0);
`else
    // r0 reads as zero in the register file, so address-0 writes are harmless and pass through.
    assign w_load = w_accept;
`endif

    // Output stage and round-robin pointer; both freeze while stall is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regwrite       <= 1'b0;
            REG_address_wb <= '0;
            data_wb        <= '0;
            grant_id       <= '0;
            r_rr_ptr       <= '0;
        end else if (!stall) begin
            regwrite <= w_load;
            if (w_load) begin
                REG_address_wb <= w_addr;
                data_wb        <= w_data;
                grant_id       <= w_win;
            end
            if (w_accept) begin
                r_rr_ptr <= w_next_ptr;
            end
        end
    end

endmodule
